seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_prescaler.sv | 27 ++
 rtl/seg7_scan_driver.sv | 108 ++++++++++
 tb/tb_seg7_scan_driver.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned DIGIT_W             = 4;
  localparam int unsigned SEL_W               = 2;
  localparam int unsigned DEFAULT_REFRESH_DIV = 100000;

  typedef logic [SEL_W-1:0]              digit_idx_t;
  typedef logic [NUM_DIGITS*DIGIT_W-1:0] disp_word_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load and digit-output signals of the scan driver; master drives loads, slave is the driver.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  disp_word_t                VALUE_IN;
  logic [NUM_DIGITS-1:0]     DOTS_IN;
  logic                      LOAD_IN;
  digit_idx_t                SEG_SELECT_OUT;
  logic [DIGIT_W-1:0]        BIN_OUT;
  logic                      DOT_OUT;
  logic                      BLANK_OUT;
  logic                      FRAME_OUT;

  modport master (
    output VALUE_IN, DOTS_IN, LOAD_IN,
    input  SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_OUT
  );

  modport slave (
    input  VALUE_IN, DOTS_IN, LOAD_IN,
    output SEG_SELECT_OUT, BIN_OUT, DOT_OUT, BLANK_OUT, FRAME_OUT
  );

endinterface

// File: rtl/seg7_prescaler.sv
// Free-running 0..Div-1 counter; tick_o is high while the counter sits at Div-1.
module seg7_prescaler #(
  parameter int unsigned Div  = 100000,
  parameter int unsigned CntW = $clog2(Div)
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntW'(Div - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 4-digit scan driver; optional leading-zero blanking via
// SEG7_LEADING_ZERO_BLANK_EN (undefined: BLANK_OUT tied low).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                CLK,
  input  logic                RESETN,
  seg7_scan_driver_if.slave   bus_io
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic                  tick;
  logic                  wrap;
  digit_idx_t            idx_q, idx_d;
  disp_word_t            disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dots_q, disp_dots_d;
  disp_word_t            pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dots_q, pend_dots_d;
  logic                  pend_q, pend_d;
  logic                  frame_q, frame_d;

  seg7_prescaler #(
    .Div  (REFRESH_DIV),
    .CntW (CNT_W)
  ) u_prescaler (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .tick_o (tick)
  );

  assign wrap = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

  always_comb begin
    idx_d       = idx_q;
    disp_val_d  = disp_val_q;
    disp_dots_d = disp_dots_q;
    pend_val_d  = pend_val_q;
    pend_dots_d = pend_dots_q;
    pend_d      = pend_q;
    frame_d     = wrap;
    if (tick) begin
      idx_d = idx_q + 1'b1;
    end
    if (wrap) begin
      // A load landing on the commit tick bypasses pending and wins.
      if (bus_io.LOAD_IN) begin
        disp_val_d  = bus_io.VALUE_IN;
        disp_dots_d = bus_io.DOTS_IN;
      end else if (pend_q) begin
        disp_val_d  = pend_val_q;
        disp_dots_d = pend_dots_q;
      end
      pend_d = 1'b0;
    end else if (bus_io.LOAD_IN) begin
      pend_val_d  = bus_io.VALUE_IN;
      pend_dots_d = bus_io.DOTS_IN;
      pend_d      = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      idx_q       <= '0;
      disp_val_q  <= '0;
      disp_dots_q <= '0;
      pend_val_q  <= '0;
      pend_dots_q <= '0;
      pend_q      <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      disp_val_q  <= disp_val_d;
      disp_dots_q <= disp_dots_d;
      pend_val_q  <= pend_val_d;
      pend_dots_q <= pend_dots_d;
      pend_q      <= pend_d;
      frame_q     <= frame_d;
    end
  end

  assign bus_io.SEG_SELECT_OUT = idx_q;
  assign bus_io.BIN_OUT        = disp_val_q[{idx_q, 2'b00} +: DIGIT_W];
  assign bus_io.DOT_OUT        = disp_dots_q[idx_q];
  assign bus_io.FRAME_OUT      = frame_q;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  zero_above;

  // Walk from the leftmost digit down; digit 0 is never blanked.
  always_comb begin
    blank_vec  = '0;
    zero_above = 1'b1;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      zero_above   = zero_above & (disp_val_q[n*DIGIT_W +: DIGIT_W] == '0);
      blank_vec[n] = zero_above & ~disp_dots_q[n];
    end
  end

  assign bus_io.BLANK_OUT = blank_vec[idx_q];
`else
  assign bus_io.BLANK_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver with REFRESH_DIV=4.
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] bin;
    logic       dot;
    logic       blank;
    logic       frame;
  } exp_t;

  exp_t sb[$];

  seg7_scan_driver_if u_if ();

  seg7_scan_driver #(
    .REFRESH_DIV (4)
  ) dut (
    .CLK    (clk),
    .RESETN (rst_n),
    .bus_io (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_blank(input logic [15:0] v, input logic [3:0] dots, input int n);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [15:0] upper;
    if (n == 0) return 1'b0;
    upper = v >> (4 * n);
    return (upper == 16'h0) && !dots[n];
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_frame(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (u_if.FRAME_OUT === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 16'(ok), 16'h1);
  endtask

  // Entered at the first cycle of a frame; leaves at the first cycle of the next one.
  task automatic run_frame(input string tag, input logic [15:0] val, input logic [3:0] dots,
                           input int a1, input logic [15:0] v1, input logic [3:0] d1,
                           input int a2, input logic [15:0] v2, input logic [3:0] d2);
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e.sel   = 2'(d);
        e.bin   = 4'(val >> (4 * d));
        e.dot   = dots[d];
        e.blank = exp_blank(val, dots, d);
        e.frame = (d == 0) && (c == 0);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 16; i++) begin
      e = sb.pop_front();
      check($sformatf("%s_c%0d_sel", tag, i), 16'(u_if.SEG_SELECT_OUT), 16'(e.sel));
      check($sformatf("%s_c%0d_bin", tag, i), 16'(u_if.BIN_OUT), 16'(e.bin));
      check($sformatf("%s_c%0d_dot", tag, i), 16'(u_if.DOT_OUT), 16'(e.dot));
      check($sformatf("%s_c%0d_blank", tag, i), 16'(u_if.BLANK_OUT), 16'(e.blank));
      check($sformatf("%s_c%0d_frame", tag, i), 16'(u_if.FRAME_OUT), 16'(e.frame));
      u_if.LOAD_IN = 1'b0;
      if (i == a1) begin
        u_if.LOAD_IN  = 1'b1;
        u_if.VALUE_IN = v1;
        u_if.DOTS_IN  = d1;
      end else if (i == a2) begin
        u_if.LOAD_IN  = 1'b1;
        u_if.VALUE_IN = v2;
        u_if.DOTS_IN  = d2;
      end
      @(negedge clk);
    end
    u_if.LOAD_IN = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"},   16'(u_if.SEG_SELECT_OUT), 16'h0);
    check({tag, "_bin"},   16'(u_if.BIN_OUT),        16'h0);
    check({tag, "_dot"},   16'(u_if.DOT_OUT),        16'h0);
    check({tag, "_blank"}, 16'(u_if.BLANK_OUT),      16'h0);
    check({tag, "_frame"}, 16'(u_if.FRAME_OUT),      16'h0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    u_if.LOAD_IN  = 1'b0;
    u_if.VALUE_IN = 16'h0;
    u_if.DOTS_IN  = 4'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Release and load 1234 in cycle 1.
    rst_n         = 1'b1;
    u_if.LOAD_IN  = 1'b1;
    u_if.VALUE_IN = 16'h1234;
    u_if.DOTS_IN  = 4'b0000;
    @(negedge clk);
    u_if.LOAD_IN = 1'b0;
    check("pre_commit_bin", 16'(u_if.BIN_OUT), 16'h0);
    wait_frame("first_frame");

    run_frame("f1", 16'h1234, 4'b0000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // ABCD loaded during digit 1: this frame must stay entirely 1234.
    run_frame("f2", 16'h1234, 4'b0000, 4, 16'hABCD, 4'b0101, -1, 16'h0, 4'h0);
    // 00F0 loaded on the commit tick itself.
    run_frame("f3", 16'hABCD, 4'b0101, 15, 16'h00F0, 4'b0000, -1, 16'h0, 4'h0);
    // Two loads in one frame: only the last may appear.
    run_frame("f4", 16'h00F0, 4'b0000, 2, 16'h1111, 4'b0011, 9, 16'h2222, 4'b0100);
    run_frame("f5", 16'h2222, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f6", 16'h2222, 4'b0100, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Asynchronous reset in the middle of digit 2.
    repeat (9) @(negedge clk);
    check("pre_rst_sel", 16'(u_if.SEG_SELECT_OUT), 16'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("post_rst_c%0d_sel", c), 16'(u_if.SEG_SELECT_OUT), 16'h0);
      check($sformatf("post_rst_c%0d_bin", c), 16'(u_if.BIN_OUT), 16'h0);
      @(negedge clk);
    end
    check("post_rst_next_sel", 16'(u_if.SEG_SELECT_OUT), 16'h1);

    // Leading-zero blanking pattern (all zero without the macro).
    u_if.LOAD_IN  = 1'b1;
    u_if.VALUE_IN = 16'h0050;
    u_if.DOTS_IN  = 4'b1000;
    @(negedge clk);
    u_if.LOAD_IN = 1'b0;
    wait_frame("blank_frame");
    run_frame("f7", 16'h0050, 4'b1000, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
